iter_seq_controller: RTL and testbench

- Runtime-parametrised sequencing controller for the iterative matrix-multiply datapath (repeated multiply/accumulate-into-register, e.g. A^n).
- Successor to the fixed-n controller: the iteration count is loaded at start, the multiplier may take several cycles (start/done handshake), and a watchdog, abort and busy/error status are added.
- Sits between the top-level start/ready interface and the datapath's init, inc, ld_reg and multiplier-control strobes.

---
 rtl/iter_seq_controller_pkg.sv | 16 +
 rtl/seq_watchdog.sv | 32 +++
 rtl/iter_seq_controller.sv | 108 ++++++++++
 tb/tb_iter_seq_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_seq_controller_pkg.sv
// Shared constants for the iterative matrix-multiply sequencer:
// state encoding and parameter defaults.
package iter_seq_controller_pkg;

   localparam int CNT_W_DEF   = 4;
   localparam int TO_W_DEF    = 8;
   localparam int TIMEOUT_DEF = 200;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INIT     = 3'd1;
   localparam logic [2:0] S_CHECK    = 3'd2;
   localparam logic [2:0] S_MUL_WAIT = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_ERR      = 3'd5;

endpackage

// File: rtl/seq_watchdog.sv
// Multiplier watchdog: counts wait cycles, flags the last one
// allowed before the sequencer gives up on mul_done.
module seq_watchdog
   import iter_seq_controller_pkg::*;
#(
   parameter int TO_W    = TO_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && !tc) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

   assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/iter_seq_controller.sv
// Sequencer for repeated multiply/accumulate: runtime iteration
// count, multi-cycle multiplier handshake, watchdog and abort.
module iter_seq_controller
   import iter_seq_controller_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TO_W    = TO_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_cfg,
   input  logic             abort,
   input  logic             mul_done,
   output logic             init,
   output logic             inc,
   output logic             mul_start,
   output logic             ld_reg,
   output logic             ready,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] idx
);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_idx;
   logic             r_err;
   logic             w_busy;
   logic             w_go;
   logic             w_lt;
   logic             w_accept;
   logic             w_tc;
   logic             w_wd_en;

   assign w_busy   = (r_state != S_IDLE) && (r_state != S_ERR);
   assign w_go     = w_busy && !abort;
   assign w_lt     = (r_idx < r_n);
   assign w_accept = start &&
                     ((r_state == S_IDLE) || (r_state == S_ERR));

   // An abort cancels every strobe of the cycle it arrives in.
   assign init      = w_go && (r_state == S_INIT);
   assign inc       = w_go && (r_state == S_CHECK) && w_lt;
   assign mul_start = inc;
   assign ld_reg    = w_go &&
                      (((r_state == S_CHECK) && !w_lt) ||
                       ((r_state == S_MUL_WAIT) && mul_done));
   assign ready     = w_go && (r_state == S_DONE);
   assign busy      = w_busy;
   assign err       = r_err;
   assign idx       = r_idx;

   assign w_wd_en = w_go && (r_state == S_MUL_WAIT) && !mul_done;

   seq_watchdog #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (inc),
      .en    (w_wd_en),
      .tc    (w_tc)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_INIT;
         S_INIT:     w_next = S_CHECK;
         S_CHECK:    w_next = w_lt ? S_MUL_WAIT : S_DONE;
         S_MUL_WAIT: begin
            if (mul_done)  w_next = S_CHECK;
            else if (w_tc) w_next = S_ERR;
         end
         S_DONE:     w_next = S_IDLE;
         S_ERR:      if (start) w_next = S_INIT;
         default:    w_next = S_IDLE;
      endcase
      if (abort && w_busy) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_idx   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_n   <= n_cfg;
            r_err <= 1'b0;
         end else if ((r_state == S_MUL_WAIT) && (w_next == S_ERR)) begin
            r_err <= 1'b1;
         end
         if (init) begin
            r_idx <= '0;
         end else if (inc) begin
            r_idx <= r_idx + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_iter_seq_controller.sv
// Bench for iter_seq_controller: fixed vector table, directed runs
// and random runs against a schedule-building reference model.
module tb_iter_seq_controller;

   localparam int TO = 5;

   typedef struct packed {
      logic       start;
      logic [3:0] n_cfg;
      logic       abort;
      logic       md;
      logic [4:0] st;
      logic       busy;
      logic       err;
      logic [3:0] idx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] n_cfg;
   logic       abort;
   logic       mul_done;
   logic       init;
   logic       inc;
   logic       mul_start;
   logic       ld_reg;
   logic       ready;
   logic       busy;
   logic       err;
   logic [3:0] idx;
   logic [10:0] w_got;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t q[$];
   vec_t tbl[12];
   int   lat[16];
   logic [3:0] m_idx;
   logic       m_err;
   int   g_c;
   int   g_ab;
   int   g_stop;
   bit   g_dead;
   bit   g_noise;
   bit   g_hold;

   always #5 clk = ~clk;

   iter_seq_controller #(
      .CNT_W   (4),
      .TO_W    (8),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .n_cfg     (n_cfg),
      .abort     (abort),
      .mul_done  (mul_done),
      .init      (init),
      .inc       (inc),
      .mul_start (mul_start),
      .ld_reg    (ld_reg),
      .ready     (ready),
      .busy      (busy),
      .err       (err),
      .idx       (idx)
   );

   assign w_got = {init, inc, mul_start, ld_reg, ready,
                   busy, err, idx};

   task automatic chk(input string nm, input logic [10:0] exp);
      n_vec++;
      if (w_got !== exp) begin
         n_bad++;
         $display("FAIL %s: got st/busy/err/idx=%b want %b",
                  nm, w_got, exp);
      end
   endtask

   task automatic apply_q(input string tag);
      vec_t v;
      for (int k = 0; k < q.size(); k++) begin
         v = q[k];
         @(posedge clk);
         #1;
         start    = v.start;
         n_cfg    = v.n_cfg;
         abort    = v.abort;
         mul_done = v.md;
         @(negedge clk);
         chk($sformatf("%s cyc%0d", tag, k),
             {v.st, v.busy, v.err, v.idx});
      end
      q.delete();
   endtask

   // One busy cycle of the schedule; ix is idx seen now, ixn after.
   task automatic put(input logic md, input logic [4:0] st,
                      input logic [3:0] ix, input logic [3:0] ixn,
                      input bit mw);
      vec_t v;
      if (g_dead) return;
      if (g_stop > 0 && g_c >= g_stop) begin
         g_dead = 1;
         return;
      end
      v.start = g_hold ? 1'b1 : (g_noise ? 1'($urandom) : 1'b0);
      v.n_cfg = 4'($urandom);
      v.abort = 1'b0;
      v.md    = mw ? md : (g_noise ? 1'($urandom) : 1'b0);
      v.st    = st;
      v.busy  = 1'b1;
      v.err   = 1'b0;
      v.idx   = ix;
      m_idx   = ixn;
      if (g_c == g_ab) begin
         v.abort = 1'b1;
         v.st    = '0;
         m_idx   = ix;
         g_dead  = 1;
      end
      q.push_back(v);
      g_c++;
   endtask

   // Expected trace of one run from the accepting cycle onward.
   task automatic gen_run(input int n, input int ab, input int stop,
                          input bit noise, input bit hold);
      vec_t v;
      g_c = 1; g_ab = ab; g_stop = stop;
      g_dead = 0; g_noise = noise; g_hold = hold;
      v.start = 1'b1;
      v.n_cfg = 4'(n);
      v.abort = 1'($urandom);
      v.md    = 1'($urandom);
      v.st    = '0;
      v.busy  = 1'b0;
      v.err   = m_err;
      v.idx   = m_idx;
      q.push_back(v);
      m_err = 1'b0;
      put(1'b0, 5'b10000, m_idx, 4'd0, 1'b0);
      for (int i = 0; i < n; i++) begin
         put(1'b0, 5'b01100, 4'(i), 4'(i + 1), 1'b0);
         if (lat[i] > TO) begin
            for (int k = 0; k < TO; k++)
               put(1'b0, 5'b00000, 4'(i + 1), 4'(i + 1), 1'b1);
            if (!g_dead) begin
               v.start = 1'b0;
               v.n_cfg = 4'($urandom);
               v.abort = 1'($urandom);
               v.md    = 1'($urandom);
               v.st    = '0;
               v.busy  = 1'b0;
               v.err   = 1'b1;
               v.idx   = 4'(i + 1);
               q.push_back(v);
               m_err  = 1'b1;
               g_dead = 1;
            end
            return;
         end
         for (int k = 1; k <= lat[i]; k++)
            put(k == lat[i], (k == lat[i]) ? 5'b00010 : 5'b00000,
                4'(i + 1), 4'(i + 1), 1'b1);
      end
      put(1'b0, 5'b00010, 4'(n), 4'(n), 1'b0);
      put(1'b0, 5'b00001, 4'(n), 4'(n), 1'b0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'd2, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0, 4'd0};
      tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b01100, 1'b1, 1'b0, 4'd0};
      tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0, 4'd1};
      tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b01100, 1'b1, 1'b0, 4'd1};
      tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 5'b00010, 1'b1, 1'b0, 4'd2};
      tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0, 4'd2};
      tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 4'd2};
      tbl[8]  = '{1'b1, 4'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4'd2};
      tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0, 4'd2};
      tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0, 4'd0};
      tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0, 4'd0};

      rst_n = 1'b0; start = 1'b0; n_cfg = '0;
      abort = 1'b0; mul_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 11'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) q.push_back(tbl[i]);
      apply_q("table");
      m_idx = 4'd0;
      m_err = 1'b0;

      lat[0] = TO + 1;
      gen_run(1, 0, 0, 0, 0);
      apply_q("timeout");
      lat[0] = 2;
      gen_run(1, 0, 0, 0, 0);
      apply_q("after_err");

      for (int i = 0; i < 16; i++) lat[i] = 1;
      gen_run(4, 5, 0, 1, 0);
      apply_q("abort");

      for (int i = 0; i < 16; i++) lat[i] = 3;
      gen_run(15, 0, 0, 0, 1);
      apply_q("n15_hold");

      for (int i = 0; i < 16; i++) lat[i] = TO;
      gen_run(3, 0, 6, 0, 0);
      apply_q("pre_rst");
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wait", 11'd0);
      start = 1'b0; abort = 1'b0; mul_done = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_held", 11'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_idx = 4'd0;
      m_err = 1'b0;
      lat[0] = 2;
      gen_run(1, 0, 0, 0, 0);
      apply_q("post_rst");

      for (int r = 0; r < 40; r++) begin
         int n;
         int ab;
         n = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++)
            lat[i] = ($urandom % 12 == 0) ? TO + 1
                                          : $urandom_range(1, TO);
         ab = ($urandom % 4 == 0) ? $urandom_range(1, 4 + 3 * n) : 0;
         gen_run(n, ab, 0, 1'($urandom), 0);
         apply_q($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
